// File: rtl/ucaspian_pkg.sv
// Shared uCaspian axon types: state encoding, table entry layout and cfg byte selectors.
package ucaspian_pkg;

    localparam int NEURON_AW   = 8;
    localparam int SYN_AW      = 10;
    localparam int NUM_NEURONS = 256;

    localparam logic [2:0] AXON_CFG_HI       = 3'd4;
    localparam logic [2:0] AXON_CFG_START_LO = 3'd5;
    localparam logic [2:0] AXON_CFG_COUNT_LO = 3'd6;

    typedef enum logic [1:0] {
        AXON_IDLE,
        AXON_LOOKUP,
        AXON_FIRE,
        AXON_CLEAR
    } axon_state_t;

    typedef struct packed {
        logic [SYN_AW-1:0] start;
        logic [SYN_AW-1:0] count;
    } axon_entry_t;

endpackage

// File: rtl/ucaspian_axon_table.sv
// 256x20 axon table: one-cycle synchronous read, write port, and a zeroing sweep.
// Sweep writes one entry per enabled cycle while i_clr is high; it restarts when i_clr drops.
module ucaspian_axon_table
    import ucaspian_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 i_rd_en,
    input  logic [NEURON_AW-1:0] i_rd_addr,
    output axon_entry_t          o_rd_dat,
    input  logic                 i_wr_en,
    input  logic [NEURON_AW-1:0] i_wr_addr,
    input  axon_entry_t          i_wr_dat,
    input  logic                 i_clr,
    output logic                 o_clr_last,
    output logic                 o_clr_done
);

    axon_entry_t          r_mem [NUM_NEURONS];
    axon_entry_t          r_rd_dat;
    logic [NEURON_AW-1:0] r_clr_addr;
    logic                 r_clr_done;

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (enable) begin
            if (i_clr && !r_clr_done) begin
                r_mem[r_clr_addr] <= '0;
            end else if (i_wr_en) begin
                r_mem[i_wr_addr] <= i_wr_dat;
            end
            if (i_rd_en) begin
                r_rd_dat <= r_mem[i_rd_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clr_addr <= '0;
            r_clr_done <= 1'b0;
        end else if (enable) begin
            if (i_clr) begin
                if (!r_clr_done) begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == {NEURON_AW{1'b1}}) begin
                        r_clr_done <= 1'b1;
                    end
                end
            end else begin
                r_clr_addr <= '0;
                r_clr_done <= 1'b0;
            end
        end
    end

    assign o_rd_dat   = r_rd_dat;
    assign o_clr_last = i_clr && !r_clr_done && (r_clr_addr == {NEURON_AW{1'b1}});
    assign o_clr_done = r_clr_done;

endmodule

// File: rtl/ucaspian_axon.sv
// Axon fire transmitter: fire id -> table lookup -> one syn_addr per synapse; first syn_vld 2 cycles after accept, then 1/cycle.
// syn_addr/syn_vld hold while syn_rdy=0; fires are refused until the burst ends. UCASPIAN_AXON_FIRE_COUNT_EN adds fire_count.
module ucaspian_axon
    import ucaspian_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 clear_act,
    input  logic                 clear_config,
    output logic                 clear_done,
    output logic                 step_done,
    input  logic [NEURON_AW-1:0] cfg_addr,
    input  logic [7:0]           cfg_value,
    input  logic [2:0]           cfg_byte,
    input  logic                 cfg_enable,
    input  logic [NEURON_AW-1:0] axon_addr,
    input  logic                 axon_vld,
    output logic                 axon_rdy,
    output logic [SYN_AW-1:0]    syn_addr,
    output logic                 syn_vld,
    input  logic                 syn_rdy
`ifdef UCASPIAN_AXON_FIRE_COUNT_EN
    ,
    output logic [15:0]          fire_count
`endif
);

    axon_state_t       r_state;
    logic [SYN_AW-1:0] r_syn_addr;
    logic              r_syn_vld;
    logic [SYN_AW-1:0] r_remain;
    logic              r_clear_done;
    logic              r_step_done;
    logic [3:0]        r_hold_hi;
    logic [7:0]        r_hold_start_lo;

    logic        w_accept;
    logic        w_syn_hs;
    logic        w_cfg_we;
    logic        w_commit;
    axon_entry_t w_commit_dat;
    axon_entry_t w_rd_dat;
    logic        w_clr_last;
    logic        w_clr_done;

    // Fires are refused while a clear is pending so no accepted id is lost.
    assign axon_rdy     = enable && (r_state == AXON_IDLE) && !clear_config && !clear_act;
    assign w_accept     = axon_vld && axon_rdy;
    assign w_syn_hs     = enable && r_syn_vld && syn_rdy;
    assign w_cfg_we     = enable && cfg_enable && !clear_config && !clear_act;
    assign w_commit     = w_cfg_we && (cfg_byte == AXON_CFG_COUNT_LO);
    assign w_commit_dat = {r_hold_hi[3:2], r_hold_start_lo, r_hold_hi[1:0], cfg_value};

    ucaspian_axon_table u_table (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .i_rd_en    (w_accept),
        .i_rd_addr  (axon_addr),
        .o_rd_dat   (w_rd_dat),
        .i_wr_en    (w_commit),
        .i_wr_addr  (cfg_addr),
        .i_wr_dat   (w_commit_dat),
        .i_clr      (clear_config),
        .o_clr_last (w_clr_last),
        .o_clr_done (w_clr_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= AXON_IDLE;
            r_syn_addr      <= '0;
            r_syn_vld       <= 1'b0;
            r_remain        <= '0;
            r_clear_done    <= 1'b0;
            r_step_done     <= 1'b0;
            r_hold_hi       <= '0;
            r_hold_start_lo <= '0;
        end else if (enable) begin
            r_step_done <= (r_state == AXON_IDLE) && !axon_vld && !r_syn_vld;
            if (clear_config) begin
                r_state      <= AXON_CLEAR;
                r_syn_vld    <= 1'b0;
                r_remain     <= '0;
                r_clear_done <= w_clr_last || w_clr_done;
            end else if (clear_act) begin
                r_state      <= AXON_IDLE;
                r_syn_vld    <= 1'b0;
                r_remain     <= '0;
                r_clear_done <= 1'b1;
            end else begin
                r_clear_done <= 1'b0;
                if (w_cfg_we && (cfg_byte == AXON_CFG_HI)) begin
                    r_hold_hi <= cfg_value[3:0];
                end
                if (w_cfg_we && (cfg_byte == AXON_CFG_START_LO)) begin
                    r_hold_start_lo <= cfg_value;
                end
                case (r_state)
                    AXON_IDLE: begin
                        if (w_accept) begin
                            r_state <= AXON_LOOKUP;
                        end
                    end
                    AXON_LOOKUP: begin
                        r_syn_addr <= w_rd_dat.start;
                        r_remain   <= w_rd_dat.count;
                        if (w_rd_dat.count == '0) begin
                            r_state <= AXON_IDLE;
                        end else begin
                            r_syn_vld <= 1'b1;
                            r_state   <= AXON_FIRE;
                        end
                    end
                    AXON_FIRE: begin
                        if (w_syn_hs) begin
                            r_syn_addr <= r_syn_addr + SYN_AW'(1);
                            r_remain   <= r_remain - SYN_AW'(1);
                            if (r_remain == SYN_AW'(1)) begin
                                r_syn_vld <= 1'b0;
                                r_state   <= AXON_IDLE;
                            end
                        end
                    end
                    default: r_state <= AXON_IDLE;
                endcase
            end
        end
    end

`ifdef UCASPIAN_AXON_FIRE_COUNT_EN
    logic [15:0] r_fire_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fire_count <= '0;
        end else if (enable) begin
            if (clear_config || clear_act) begin
                r_fire_count <= '0;
            end else if (w_syn_hs && (r_fire_count != 16'hFFFF)) begin
                r_fire_count <= r_fire_count + 16'd1;
            end
        end
    end

    assign fire_count = r_fire_count;
`endif

    assign syn_addr   = r_syn_addr;
    assign syn_vld    = r_syn_vld && enable;
    assign clear_done = r_clear_done;
    assign step_done  = r_step_done;

endmodule

// File: tb/tb_ucaspian_axon.sv
// Directed and randomized bench for ucaspian_axon against an array model of the axon table.
module tb_ucaspian_axon;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       clear_act = 1'b0;
    logic       clear_config = 1'b0;
    logic       clear_done;
    logic       step_done;
    logic [7:0] cfg_addr = '0;
    logic [7:0] cfg_value = '0;
    logic [2:0] cfg_byte = '0;
    logic       cfg_enable = 1'b0;
    logic [7:0] axon_addr = '0;
    logic       axon_vld = 1'b0;
    logic       axon_rdy;
    logic [9:0] syn_addr;
    logic       syn_vld;
    logic       syn_rdy = 1'b0;
`ifdef UCASPIAN_AXON_FIRE_COUNT_EN
    logic [15:0] fire_count;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    int         m_start [256];
    int         m_count [256];
    logic [9:0] got [$];

    always #5 clk = ~clk;

    ucaspian_axon dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .clear_act    (clear_act),
        .clear_config (clear_config),
        .clear_done   (clear_done),
        .step_done    (step_done),
        .cfg_addr     (cfg_addr),
        .cfg_value    (cfg_value),
        .cfg_byte     (cfg_byte),
        .cfg_enable   (cfg_enable),
        .axon_addr    (axon_addr),
        .axon_vld     (axon_vld),
        .axon_rdy     (axon_rdy),
        .syn_addr     (syn_addr),
        .syn_vld      (syn_vld),
        .syn_rdy      (syn_rdy)
`ifdef UCASPIAN_AXON_FIRE_COUNT_EN
        ,
        .fire_count   (fire_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int id, input int st, input int cnt);
        logic [9:0] s;
        logic [9:0] c;
        s = st[9:0];
        c = cnt[9:0];
        cfg_addr   = id[7:0];
        cfg_enable = 1'b1;
        cfg_byte = 3'd4; cfg_value = {4'h0, s[9:8], c[9:8]}; tick();
        cfg_byte = 3'd3; cfg_value = 8'hFF;                   tick();
        cfg_byte = 3'd5; cfg_value = s[7:0];                  tick();
        cfg_byte = 3'd6; cfg_value = c[7:0];                  tick();
        cfg_enable = 1'b0;
        m_start[id] = st;
        m_count[id] = cnt;
    endtask

    // Fires one id and collects every completed handshake until the unit is idle again.
    task automatic fire(input int id, input int rdy_pct, output int lat, output int idle_cyc);
        int cyc;
        bit done;
        got.delete();
        lat = -1;
        done = 1'b0;
        for (int w = 0; w < 20 && !axon_rdy; w++) tick();
        chk("fire_rdy_before_accept", axon_rdy, 1);
        axon_addr = id[7:0];
        axon_vld  = 1'b1;
        tick();
        axon_vld = 1'b0;
        cyc = 1;
        while (cyc < 3000) begin
            syn_rdy = ($urandom_range(99) < rdy_pct);
            if (syn_vld && lat < 0) lat = cyc;
            if (syn_vld && syn_rdy) got.push_back(syn_addr);
            if (!syn_vld && axon_rdy) begin
                done = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
        idle_cyc = cyc;
        chk("fire_completes", done, 1);
    endtask

    task automatic check_burst(input int id);
        chk("burst_len", got.size(), m_count[id]);
        for (int i = 0; i < got.size() && i < m_count[id]; i++)
            chk("burst_addr", got[i], (m_start[id] + i) % 1024);
    endtask

    task automatic clear_table();
        clear_config = 1'b1;
        repeat (255) tick();
        chk("clr_done_early", clear_done, 0);
        chk("clr_rdy_low", axon_rdy, 0);
        tick();
        chk("clr_done_256", clear_done, 1);
        tick();
        chk("clr_done_held", clear_done, 1);
        clear_config = 1'b0;
        tick();
        chk("clr_done_drop", clear_done, 0);
        chk("clr_back_idle", axon_rdy, 1);
        for (int i = 0; i < 256; i++) begin
            m_start[i] = 0;
            m_count[i] = 0;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int idle_cyc;
        int ids [8];

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_syn_vld", syn_vld, 0);
        chk("rst_syn_addr", syn_addr, 0);
        chk("rst_clear_done", clear_done, 0);
        chk("rst_step_done", step_done, 0);
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();
        chk("step_done_idle", step_done, 1);

        clear_table();
        prog(5, 100, 3);
        prog(7, 1022, 4);

        // Basic burst, latency and throughput
        fire(5, 100, lat, idle_cyc);
        chk("id5_latency", lat, 2);
        chk("id5_idle_cycle", idle_cyc, 5);
        check_burst(5);
`ifdef UCASPIAN_AXON_FIRE_COUNT_EN
        chk("fire_count_3", fire_count, 3);
`endif

        // Address wrap
        fire(7, 100, lat, idle_cyc);
        chk("id7_latency", lat, 2);
        check_burst(7);

        // Zero-count entry
        fire(9, 100, lat, idle_cyc);
        chk("id9_no_vld", lat, -1);
        chk("id9_rdy_2cyc", idle_cyc, 2);
        check_burst(9);
        tick();
        chk("id9_step_done", step_done, 1);

        // Stall mid-burst
        syn_rdy = 1'b1;
        chk("stall_rdy", axon_rdy, 1);
        axon_addr = 8'd5; axon_vld = 1'b1; tick(); axon_vld = 1'b0;
        tick();
        chk("stall_first_vld", syn_vld, 1);
        chk("stall_first_addr", syn_addr, 100);
        tick();
        chk("stall_second_addr", syn_addr, 101);
        syn_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold_vld", syn_vld, 1);
            chk("stall_hold_addr", syn_addr, 101);
        end
        syn_rdy = 1'b1;
        tick();
        chk("stall_resume_addr", syn_addr, 102);
        chk("stall_resume_vld", syn_vld, 1);
        tick();
        chk("stall_end_vld", syn_vld, 0);
        chk("stall_end_rdy", axon_rdy, 1);

        // enable=0 freezes the burst
        axon_addr = 8'd7; axon_vld = 1'b1; tick(); axon_vld = 1'b0;
        tick();
        chk("en_first_addr", syn_addr, 1022);
        tick();
        chk("en_second_addr", syn_addr, 1023);
        enable = 1'b0;
        #1;
        chk("en_vld_gated", syn_vld, 0);
        chk("en_rdy_gated", axon_rdy, 0);
        repeat (3) tick();
        chk("en_addr_frozen", syn_addr, 1023);
        chk("en_still_gated", syn_vld, 0);
        enable = 1'b1;
        #1;
        chk("en_resume_vld", syn_vld, 1);
        chk("en_resume_addr", syn_addr, 1023);
        tick();
        chk("en_wrap_addr", syn_addr, 0);
        tick();
        chk("en_last_addr", syn_addr, 1);
        tick();
        chk("en_end_vld", syn_vld, 0);

        // clear_act aborts the burst
        axon_addr = 8'd5; axon_vld = 1'b1; tick(); axon_vld = 1'b0;
        tick();
        tick();
        chk("abort_mid_addr", syn_addr, 101);
        clear_act = 1'b1;
        tick();
        chk("abort_vld", syn_vld, 0);
        chk("abort_done", clear_done, 1);
        tick();
        chk("abort_done_held", clear_done, 1);
        clear_act = 1'b0;
        tick();
        chk("abort_done_drop", clear_done, 0);
        fire(5, 100, lat, idle_cyc);
        check_burst(5);

        // clear_config wipes the table
        clear_table();
        fire(5, 100, lat, idle_cyc);
        chk("cleared_no_vld", lat, -1);
        check_burst(5);

        // Randomized table contents and ready pattern
        for (int i = 0; i < 8; i++) begin
            ids[i] = $urandom_range(255);
            prog(ids[i], $urandom_range(1023), $urandom_range(15));
        end
        for (int k = 0; k < 12; k++) begin
            int id;
            id = ids[$urandom_range(7)];
            fire(id, 70, lat, idle_cyc);
            check_burst(id);
        end

        // Async reset in the middle of a burst
        prog(7, 1022, 4);
        syn_rdy = 1'b1;
        axon_addr = 8'd7; axon_vld = 1'b1; tick(); axon_vld = 1'b0;
        tick();
        chk("rst_mid_vld_before", syn_vld, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_vld", syn_vld, 0);
        chk("rst_mid_addr", syn_addr, 0);
        chk("rst_mid_step_done", step_done, 0);
        reset_n = 1'b1;
        #1;
        chk("rst_rel_step_done", step_done, 0);
        tick();
        chk("rst_rel_step_done_reg", step_done, 1);
        chk("rst_rel_rdy", axon_rdy, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ucaspian_axon.md
Name: ucaspian_axon

Overview:
- Transmitter side of the axon→synapse fire interface.
- Accepts a fire for one neuron (8-bit id) and looks up that neuron's contiguous outgoing synapse range (start address, count) in a 256-entry config RAM.
- Issues one syn_addr per outgoing synapse on a valid/ready handshake to the synapse unit.
- Sits between the neuron/threshold stage and the synapse unit. Runs on the same cfg bus and step/clear protocol as the other uCaspian units.

Parameters:
- NUM_NEURONS, 256, number of axon table entries (addressed by 8-bit id).
- SYN_AW, 10, synapse address width; also the count width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  advance when high; freeze when low
- clear_act  in  1  abort in-flight fire, return to idle
- clear_config  in  1  zero the whole axon table
- clear_done  out  1  clear complete
- step_done  out  1  unit idle, no pending work
- cfg_addr  in  8  neuron id being configured
- cfg_value  in  8  config byte
- cfg_byte  in  3  byte selector
- cfg_enable  in  1  config write strobe
- axon_addr  in  8  firing neuron id
- axon_vld  in  1  fire valid
- axon_rdy  out  1  fire accepted when vld&&rdy
- syn_addr  out  10  synapse address to fire
- syn_vld  out  1  synapse fire valid
- syn_rdy  in  1  synapse unit ready

Behaviour:
- Reset (async, reset_n=0): state=IDLE; syn_addr=0, syn_vld=0, clear_done=0, step_done=0, all counters 0. Table contents are undefined until clear_config or cfg.
- Table entry is 20 bits: start[9:0], count[9:0]. count=0 means no outgoing synapses.
- Cfg writes are accepted only when clear_config=0:
  - byte 4: hold_hi <= cfg_value[3:0] = {start[9:8], count[9:8]}.
  - byte 5: hold_start_lo <= cfg_value.
  - byte 6: commit table[cfg_addr] <= {hold_hi[3:2], hold_start_lo, hold_hi[1:0], cfg_value}.
  - Other byte values are ignored.
- The table has a synchronous read (BRAM), one-cycle latency.
- States: IDLE, LOOKUP, FIRE, CLEAR.
  - IDLE: axon_rdy = enable. On axon_vld&&axon_rdy, latch the id, issue the RAM read, go to LOOKUP.
  - LOOKUP (1 cycle): load cur <= start and remain <= count.
    - count=0: go to IDLE, no syn_vld.
    - Otherwise: syn_addr <= start, syn_vld <= 1, go to FIRE.
  - FIRE: on syn_vld&&syn_rdy, syn_addr <= syn_addr+1 (mod 1024, wraps 1023→0) and remain <= remain-1.
    - If remain==1: syn_vld <= 0, go to IDLE.
    - syn_addr and syn_vld stay stable while syn_rdy=0.
  - CLEAR: entered from any state when clear_config=1. Writes 0 to table[i] for i=0..255, one per cycle. After entry 255 is written, clear_done=1 and holds while clear_config=1. When clear_config drops: clear_done=0, state=IDLE.
- Latency: fire accepted at cycle N, first syn_vld at cycle N+2. Steady state issues 1 synapse per cycle with syn_rdy held high.
- axon_rdy=0 in LOOKUP, FIRE and CLEAR. A new fire is accepted no earlier than the cycle after the last synapse handshake.
- enable=0: all registers hold; axon_rdy=0; syn_vld output is gated to 0, so no handshake can complete. Resumes exactly where it stopped.
- clear_act (lower priority than clear_config): syn_vld=0, state=IDLE, remaining synapses dropped, clear_done=1 next cycle and held while clear_act=1.
- Priority: reset_n > clear_config > clear_act > cfg/normal.
- step_done is registered: (state==IDLE) && !axon_vld && !syn_vld.

Optional Feature:
- UCASPIAN_AXON_FIRE_COUNT_EN defined: adds output fire_count[15:0].
  - Increments on every syn_vld&&syn_rdy; saturates at 0xFFFF.
  - Cleared by reset_n, clear_act and clear_config.
- Undefined: the port and counter are absent, with no other change.

Decomposition:
- ucaspian_pkg: axon state enum (IDLE/LOOKUP/FIRE/CLEAR), cfg byte constants (AXON_CFG_HI=4, AXON_CFG_START_LO=5, AXON_CFG_COUNT_LO=6), SYN_AW, NEURON_AW=8.
- One sub-module: ucaspian_axon_table, a 256x20 sync-read RAM with a write port and a clear-sweep port (clear address counter, done flag).

Test Plan:
- Program id 5 = {start=100, count=3}. Fire 5 with syn_rdy=1 → syn_addr 100, 101, 102 on consecutive cycles starting 2 cycles after accept; then syn_vld=0 and axon_rdy=1.
- Program id 7 = {start=1022, count=4}. Fire 7 → syn_addr 1022, 1023, 0, 1 (wrap).
- Fire an id with count=0 → no syn_vld; axon_rdy back high 2 cycles after accept; step_done=1 after axon_vld drops.
- Stall: syn_rdy=0 for 5 cycles mid-burst on id 5 → syn_addr held at 101, syn_vld held; burst resumes 101, 102 with no loss or duplicate.
- clear_act asserted after the first handshake of id 5 → syn_vld=0 next cycle, clear_done=1; refire 5 → full burst 100–102. Then clear_config → clear_done after 256 cycles; refire 5 → no syn_vld.
- reset_n pulsed low mid-FIRE → syn_vld=0 immediately (async), state IDLE, step_done=0 until first registered update.
